// File: rtl/irq_stim_pkg.sv
// Shared definitions for the PC-triggered interrupt stimulus generator.
// Optional feature macro: IRQ_TIMEOUT_EN (forced drop of long-held interrupts).
package irq_stim_pkg;

    typedef logic [2:0] chan_state_t;

    // Channel FSM states
    localparam chan_state_t StIdle   = 3'd0;
    localparam chan_state_t StArmed  = 3'd1;
    localparam chan_state_t StDelay  = 3'd2;
    localparam chan_state_t StAssert = 3'd3;
    localparam chan_state_t StDone   = 3'd4;

    // Byte distance between consecutive channel acknowledge words
    localparam int unsigned ACK_STRIDE = 4;

    // PCs and store addresses are compared as word addresses
    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

    // Saturating add of up to 16 simultaneous assertion pulses
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [4:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {12'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/irq_stim_chan.sv
// One interrupt channel: trigger-edge detect, delay, assert until ack, fire budget.
// With IRQ_TIMEOUT_EN defined, an assert-cycle counter forces a drop after TIMEOUT cycles.
module irq_stim_chan
    import irq_stim_pkg::*;
#(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned DLY_W = 8
`ifdef IRQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 1024
`endif
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [31:0]      pc_i,        // already word-masked
    input  logic [31:0]      prev_pc_i,   // already word-masked
    input  logic             ack_i,
    input  logic             cfg_we_i,
    input  logic [31:0]      cfg_pc_i,
    input  logic [CNT_W-1:0] cfg_count_i,
    input  logic [DLY_W-1:0] cfg_delay_i,
    output logic             irq_o,
    output logic             fire_o,      // one-cycle pulse on entry to assert
    output logic             timeout_err_o
);

    chan_state_t      state_q, state_d;
    logic [31:0]      cfg_pc_q, cfg_pc_d;
    logic [CNT_W-1:0] cfg_count_q, cfg_count_d;
    logic [DLY_W-1:0] cfg_delay_q, cfg_delay_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [CNT_W-1:0] fired_q, fired_d;
    logic             trig;

`ifdef IRQ_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_q, to_d;
    logic            err_q, err_d;
`endif

    // PC arriving at the trigger word; a PC parked there does not retrigger
    assign trig = (pc_i == cfg_pc_q) && (prev_pc_i != cfg_pc_q);

    // Next-state: config write wins, then per-state behaviour
    always_comb begin
        state_d     = state_q;
        cfg_pc_d    = cfg_pc_q;
        cfg_count_d = cfg_count_q;
        cfg_delay_d = cfg_delay_q;
        dly_d       = dly_q;
        fired_d     = fired_q;
        fire_o      = 1'b0;
`ifdef IRQ_TIMEOUT_EN
        to_d        = to_q;
        err_d       = err_q;
`endif
        if (cfg_we_i) begin
            cfg_pc_d    = cfg_pc_i & PC_MASK;
            cfg_count_d = cfg_count_i;
            cfg_delay_d = cfg_delay_i;
            fired_d     = '0;
            dly_d       = '0;
            state_d     = (cfg_count_i != '0) ? StArmed : StIdle;
        end else begin
            case (state_q)
                StArmed: begin
                    if (trig) begin
                        if (cfg_delay_q == '0) begin
                            state_d = StAssert;
                            fire_o  = 1'b1;
                            fired_d = fired_q + CNT_W'(1);
`ifdef IRQ_TIMEOUT_EN
                            to_d    = '0;
`endif
                        end else begin
                            state_d = StDelay;
                            dly_d   = cfg_delay_q - DLY_W'(1);
                        end
                    end
                end
                StDelay: begin
                    if (dly_q == '0) begin
                        state_d = StAssert;
                        fire_o  = 1'b1;
                        fired_d = fired_q + CNT_W'(1);
`ifdef IRQ_TIMEOUT_EN
                        to_d    = '0;
`endif
                    end else begin
                        dly_d = dly_q - DLY_W'(1);
                    end
                end
                StAssert: begin
                    if (ack_i) begin
                        state_d = (fired_q < cfg_count_q) ? StArmed : StDone;
                    end
`ifdef IRQ_TIMEOUT_EN
                    else if (to_q == TO_W'(TIMEOUT - 1)) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end else begin
                        to_d = to_q + TO_W'(1);
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // State and configuration registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            cfg_pc_q    <= '0;
            cfg_count_q <= '0;
            cfg_delay_q <= '0;
            dly_q       <= '0;
            fired_q     <= '0;
        end else begin
            state_q     <= state_d;
            cfg_pc_q    <= cfg_pc_d;
            cfg_count_q <= cfg_count_d;
            cfg_delay_q <= cfg_delay_d;
            dly_q       <= dly_d;
            fired_q     <= fired_d;
        end
    end

`ifdef IRQ_TIMEOUT_EN
    // Assert-cycle counter and sticky timeout flag
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            to_q  <= '0;
            err_q <= 1'b0;
        end else begin
            to_q  <= to_d;
            err_q <= err_d;
        end
    end
    assign timeout_err_o = err_q;
`else
    assign timeout_err_o = 1'b0;
`endif

    assign irq_o = (state_q == StAssert);

endmodule

// File: rtl/irq_stimulus_gen.sv
// Multi-channel PC-triggered interrupt source for CPU benches.
// Optional feature macro: IRQ_TIMEOUT_EN (forced drop after TIMEOUT assert cycles).
module irq_stimulus_gen
    import irq_stim_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned DLY_W    = 8,
    parameter logic [31:0] ACK_BASE = 32'h7F20,
    parameter int unsigned TIMEOUT  = 1024,
    localparam int unsigned IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       macroscopic_pc,
    input  logic [31:0]       m_data_addr,
    input  logic [3:0]        m_data_byteen,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [31:0]       cfg_pc,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic [DLY_W-1:0]  cfg_delay,
    output logic              interrupt,
    output logic [NUM_CH-1:0] irq_vec,
    output logic [15:0]       fire_total,
    output logic [NUM_CH-1:0] timeout_err
);

    if (NUM_CH < 1 || NUM_CH > 16 || TIMEOUT < 1) begin : g_bad_params
        $error("irq_stimulus_gen: NUM_CH must be 1..16 and TIMEOUT nonzero");
    end

    logic [31:0]       pc_m, addr_m;
    logic [31:0]       prev_pc_q;
    logic              store;
    logic [NUM_CH-1:0] ack, cfg_sel, fire;
    logic [4:0]        fire_cnt;
    logic [15:0]       fire_total_q, fire_total_d;

    assign pc_m   = macroscopic_pc & PC_MASK;
    assign addr_m = m_data_addr & PC_MASK;
    assign store  = |m_data_byteen;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        assign ack[i]     = store && (addr_m == ACK_BASE + 32'(ACK_STRIDE * i));
        assign cfg_sel[i] = cfg_we && (cfg_idx == IDX_W'(i));

        irq_stim_chan #(
            .CNT_W   (CNT_W),
            .DLY_W   (DLY_W)
`ifdef IRQ_TIMEOUT_EN
            ,
            .TIMEOUT (TIMEOUT)
`endif
        ) u_chan (
            .clk_i         (clk),
            .reset_i       (reset),
            .pc_i          (pc_m),
            .prev_pc_i     (prev_pc_q),
            .ack_i         (ack[i]),
            .cfg_we_i      (cfg_sel[i]),
            .cfg_pc_i      (cfg_pc),
            .cfg_count_i   (cfg_count),
            .cfg_delay_i   (cfg_delay),
            .irq_o         (irq_vec[i]),
            .fire_o        (fire[i]),
            .timeout_err_o (timeout_err[i])
        );
    end

    // Number of channels entering assert this cycle, folded into the saturating total
    always_comb begin
        fire_cnt = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            fire_cnt = fire_cnt + 5'(fire[k]);
        end
        fire_total_d = sat_add16(fire_total_q, fire_cnt);
    end

    // Previous masked PC for edge detection, and the assertion total
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_pc_q    <= '0;
            fire_total_q <= '0;
        end else begin
            prev_pc_q    <= pc_m;
            fire_total_q <= fire_total_d;
        end
    end

    assign interrupt  = |irq_vec;
    assign fire_total = fire_total_q;

endmodule

// File: tb/tb_irq_stimulus_gen.sv
// Directed self-checking bench for irq_stimulus_gen (NUM_CH=4, TIMEOUT=16).
module tb_irq_stimulus_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] macroscopic_pc = 32'h3000;
    logic [31:0] m_data_addr = 32'h0;
    logic [3:0]  m_data_byteen = 4'h0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = 2'd0;
    logic [31:0] cfg_pc = 32'h0;
    logic [3:0]  cfg_count = 4'd0;
    logic [7:0]  cfg_delay = 8'd0;
    logic        interrupt;
    logic [3:0]  irq_vec;
    logic [15:0] fire_total;
    logic [3:0]  timeout_err;

    int n_total = 0;
    int n_bad   = 0;

    irq_stimulus_gen #(
        .NUM_CH   (4),
        .CNT_W    (4),
        .DLY_W    (8),
        .ACK_BASE (32'h7F20),
        .TIMEOUT  (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .macroscopic_pc (macroscopic_pc),
        .m_data_addr    (m_data_addr),
        .m_data_byteen  (m_data_byteen),
        .cfg_we         (cfg_we),
        .cfg_idx        (cfg_idx),
        .cfg_pc         (cfg_pc),
        .cfg_count      (cfg_count),
        .cfg_delay      (cfg_delay),
        .interrupt      (interrupt),
        .irq_vec        (irq_vec),
        .fire_total     (fire_total),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_pc(input logic [31:0] v);
        macroscopic_pc = v;
        tick();
    endtask

    task automatic cfg(input int idx, input logic [31:0] pc, input int cnt, input int dly);
        cfg_idx   = 2'(idx);
        cfg_pc    = pc;
        cfg_count = 4'(cnt);
        cfg_delay = 8'(dly);
        cfg_we    = 1'b1;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic store(input logic [31:0] addr);
        m_data_addr   = addr;
        m_data_byteen = 4'hF;
        tick();
        m_data_byteen = 4'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_irq_vec", irq_vec, 4'h0);
        check("rst_interrupt", interrupt, 1'b0);
        check("rst_fire_total", fire_total, 16'd0);
        check("rst_timeout_err", timeout_err, 4'h0);

        // T1: single shot, delay 0
        cfg(0, 32'h3018, 1, 0);
        check("t1_armed_quiet", irq_vec, 4'h0);
        set_pc(32'h3018);
        check("t1_irq_rise", irq_vec, 4'h1);
        check("t1_interrupt", interrupt, 1'b1);
        check("t1_fire_total", fire_total, 16'd1);
        repeat (3) tick();
        check("t1_irq_held", irq_vec, 4'h1);
        store(32'h7F22);
        check("t1_irq_drop", irq_vec, 4'h0);
        check("t1_int_drop", interrupt, 1'b0);
        set_pc(32'h3000);
        set_pc(32'h3018);
        tick();
        check("t1_no_refire", irq_vec, 4'h0);
        check("t1_total_final", fire_total, 16'd1);

        // T2: three fires with delay 5, then exhausted
        do_reset();
        cfg(1, 32'h3100, 3, 5);
        for (int p = 0; p < 3; p++) begin
            set_pc(32'h3000);
            macroscopic_pc = 32'h3100;
            repeat (5) tick();
            check($sformatf("t2_pre_%0d", p), irq_vec, 4'h0);
            tick();
            check($sformatf("t2_rise_%0d", p), irq_vec, 4'h2);
            store(32'h7F24);
            check($sformatf("t2_drop_%0d", p), irq_vec, 4'h0);
        end
        check("t2_fire_total", fire_total, 16'd3);
        set_pc(32'h3000);
        macroscopic_pc = 32'h3100;
        repeat (8) tick();
        check("t2_fourth_quiet", irq_vec, 4'h0);
        check("t2_total_final", fire_total, 16'd3);

        // T3: PC parked on the trigger fires once; cfg_pc low bits dropped
        do_reset();
        cfg(2, 32'h4001, 2, 0);
        set_pc(32'h4002);
        check("t3_rise", irq_vec, 4'h4);
        store(32'h7F28);
        repeat (8) tick();
        check("t3_parked_quiet", irq_vec, 4'h0);
        check("t3_one_fire", fire_total, 16'd1);
        set_pc(32'h3000);
        set_pc(32'h4000);
        check("t3_second_edge", irq_vec, 4'h4);
        check("t3_total_two", fire_total, 16'd2);

        // T4: two channels together, independent acks
        do_reset();
        cfg(0, 32'h5000, 1, 0);
        cfg(2, 32'h5000, 1, 0);
        set_pc(32'h5000);
        check("t4_both", irq_vec, 4'h5);
        check("t4_total_two", fire_total, 16'd2);
        store(32'h7F30);
        check("t4_out_of_range", irq_vec, 4'h5);
        m_data_addr = 32'h7F20;
        tick();
        check("t4_no_byteen", irq_vec, 4'h5);
        store(32'h7F28);
        check("t4_ack2_vec", irq_vec, 4'h1);
        check("t4_ack2_int", interrupt, 1'b1);
        store(32'h7F20);
        check("t4_ack0_vec", irq_vec, 4'h0);
        check("t4_ack0_int", interrupt, 1'b0);

        // T5: reset in the middle of a delay and an assertion
        do_reset();
        cfg(0, 32'h6000, 1, 10);
        cfg(1, 32'h6000, 1, 0);
        set_pc(32'h6000);
        repeat (3) tick();
        check("t5_pre_vec", irq_vec, 4'h2);
        check("t5_pre_total", fire_total, 16'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rst_vec", irq_vec, 4'h0);
        check("t5_rst_total", fire_total, 16'd0);
        repeat (12) tick();
        check("t5_no_resume", irq_vec, 4'h0);
        set_pc(32'h3000);
        set_pc(32'h6000);
        repeat (12) tick();
        check("t5_unconfigured", irq_vec, 4'h0);
        cfg(0, 32'h6000, 1, 0);
        set_pc(32'h3000);
        set_pc(32'h6000);
        check("t5_reconfigured", irq_vec, 4'h1);

        // T6: no ack
        do_reset();
        cfg(0, 32'h7000, 1, 0);
        set_pc(32'h7000);
        check("t6_rise", irq_vec, 4'h1);
`ifdef IRQ_TIMEOUT_EN
        repeat (15) tick();
        check("t6_last_cycle", irq_vec, 4'h1);
        tick();
        check("t6_timeout_drop", irq_vec, 4'h0);
        check("t6_timeout_err", timeout_err, 4'h1);
        cfg(0, 32'h7000, 1, 0);
        check("t6_err_sticky", timeout_err, 4'h1);
`else
        repeat (120) tick();
        check("t6_held_long", irq_vec, 4'h1);
        check("t6_no_err", timeout_err, 4'h0);
        store(32'h7F20);
        check("t6_ack_drop", irq_vec, 4'h0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
